// File: rtl/color_detector_pkg.sv
// Shared encodings for the colour detector: result codes, FSM states,
// RGB332 field positions and the saturating counter helper.
package color_detector_pkg;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_RED  = 2'b01,
      RES_BLUE = 2'b10
   } result_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DECIDE = 2'd2,
      REPORT = 2'd3
   } state_e;

   // RGB332 layout: R=[7:5], G=[4:2], B=[1:0]
   localparam int R_MSB = 7;
   localparam int R_LSB = 5;
   localparam int G_MSB = 4;
   localparam int G_LSB = 2;
   localparam int B_MSB = 1;
   localparam int B_LSB = 0;

   localparam int CNT_W = 15;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/color_detector_pixel_classifier.sv
// Purely combinational red/blue classification of one RGB332 pixel.
module pixel_classifier
   import color_detector_pkg::*;
(
   input  logic [7:0] pixel,
   output logic       is_red,
   output logic       is_blue
);

   logic [2:0] r;
   logic [2:0] g;
   logic [1:0] b;

   assign r = pixel[R_MSB:R_LSB];
   assign g = pixel[G_MSB:G_LSB];
   assign b = pixel[B_MSB:B_LSB];

   assign is_red  = (r >= 3'd4) && (g <= 3'd2) && (b <= 2'd1);
   assign is_blue = (b == 2'd3) && (r <= 3'd2) && (g <= 3'd3);

endmodule

// File: rtl/color_detector.sv
// Per-frame red/blue pixel counter with thresholded, debounced colour result.
module color_detector
   import color_detector_pkg::*;
#(
   parameter logic [CNT_W-1:0] THRESH   = 15'd2000,
   parameter int unsigned      CONFIRM  = 2,   // 1..7
   parameter int unsigned      H_ACTIVE = 176,
   parameter int unsigned      V_ACTIVE = 144
)(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [7:0]       PIXEL_COLOR,
   input  logic             W_EN,
   input  logic [9:0]       X,
   input  logic [9:0]       Y,
   input  logic             VSYNC,
   output logic [1:0]       RESULT,
   output logic             RESULT_VALID,
   output logic [CNT_W-1:0] RED_CNT,
   output logic [CNT_W-1:0] BLUE_CNT
);

   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
   localparam logic [2:0] CONF  = 3'(CONFIRM);

   state_e           state, state_nx;
   logic             vsync_q;
   logic             blank_seen;
   logic [CNT_W-1:0] red_acc, blue_acc;
   logic [2:0]       run, run_nx;
   result_e          prev_cand, cand;
   logic             is_red, is_blue;
   logic             accept;
   logic             vsync_rise;

   pixel_classifier u_cls (
      .pixel   (PIXEL_COLOR),
      .is_red  (is_red),
      .is_blue (is_blue)
   );

   assign accept     = (state == ACCUM) && W_EN && !VSYNC && (X < H_LIM) && (Y < V_LIM);
   assign vsync_rise = VSYNC && !vsync_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   // Leaving IDLE needs a blanking interval seen since reset, so a frame
   // interrupted by reset is dropped instead of reported as a partial one.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!VSYNC && blank_seen) state_nx = ACCUM;
         ACCUM:   if (vsync_rise) state_nx = DECIDE;
         DECIDE:  state_nx = REPORT;
         REPORT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cand = RES_NONE;
      if (red_acc >= THRESH && red_acc > blue_acc)
         cand = RES_RED;
      else if (blue_acc >= THRESH && blue_acc > red_acc)
         cand = RES_BLUE;
      run_nx = 3'd1;
      if (cand == prev_cand)
         run_nx = (run >= CONF) ? CONF : run + 3'd1;
   end

   // Decision state is registered at the end of DECIDE so that RESULT,
   // RESULT_VALID and the counts all become visible during REPORT.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         vsync_q      <= 1'b1;
         blank_seen   <= 1'b0;
         red_acc      <= '0;
         blue_acc     <= '0;
         run          <= 3'd0;
         prev_cand    <= RES_NONE;
         RESULT       <= RES_NONE;
         RESULT_VALID <= 1'b0;
         RED_CNT      <= '0;
         BLUE_CNT     <= '0;
      end else begin
         vsync_q      <= VSYNC;
         RESULT_VALID <= (state == DECIDE);
         if (VSYNC) blank_seen <= 1'b1;
         if (state == DECIDE) begin
            RED_CNT   <= red_acc;
            BLUE_CNT  <= blue_acc;
            red_acc   <= '0;
            blue_acc  <= '0;
            prev_cand <= cand;
            run       <= run_nx;
            if (run_nx == CONF) RESULT <= cand;
         end else if (accept) begin
            if (is_red)  red_acc  <= sat_inc(red_acc);
            if (is_blue) blue_acc <= sat_inc(blue_acc);
         end
      end
   end

endmodule

// File: tb/tb_color_detector.sv
// Directed-frame bench for color_detector with a per-cycle reference model.
module tb_color_detector;

   localparam int H    = 176;
   localparam int V    = 144;
   localparam int CONF = 2;
   localparam int THR  = 2000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  PIXEL_COLOR = 8'h00;
   logic        W_EN = 1'b0;
   logic [9:0]  X = 10'd0;
   logic [9:0]  Y = 10'd0;
   logic        VSYNC = 1'b1;
   logic [1:0]  RESULT;
   logic        RESULT_VALID;
   logic [14:0] RED_CNT;
   logic [14:0] BLUE_CNT;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   color_detector #(
      .THRESH   (15'd2000),
      .CONFIRM  (CONF),
      .H_ACTIVE (H),
      .V_ACTIVE (V)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .PIXEL_COLOR  (PIXEL_COLOR),
      .W_EN         (W_EN),
      .X            (X),
      .Y            (Y),
      .VSYNC        (VSYNC),
      .RESULT       (RESULT),
      .RESULT_VALID (RESULT_VALID),
      .RED_CNT      (RED_CNT),
      .BLUE_CNT     (BLUE_CNT)
   );

   // 1 = red, 2 = blue, 0 = neither
   function automatic int classify(input logic [7:0] c);
      int r = int'(c[7:5]);
      int g = int'(c[4:2]);
      int b = int'(c[1:0]);
      if (r >= 4 && g <= 2 && b <= 1) return 1;
      if (b == 3 && r <= 2 && g <= 3) return 2;
      return 0;
   endfunction

   // Reference model: frame counts, a report two edges after the blanking
   // rise, and RESULT following the last CONF identical frame decisions.
   int m_red, m_blue, m_busy, st_red, st_blue, st_cand;
   bit m_active, m_armed, m_stage, m_seen_rst;
   bit m_prev_v = 1'b1;
   int e_red = 0, e_blue = 0, e_result = 0, e_valid = 0;
   int hist[$];
   bit same;

   always @(posedge CLK) begin
      if (!RST_N) begin
         m_seen_rst = 1; m_red = 0; m_blue = 0; m_active = 0; m_armed = 0;
         m_prev_v = 1; m_busy = 0; m_stage = 0;
         e_red = 0; e_blue = 0; e_result = 0; e_valid = 0;
         hist.delete();
      end else begin
         e_valid = 0;
         if (m_stage) begin
            e_red = st_red; e_blue = st_blue; e_valid = 1; m_stage = 0;
            hist.push_back(st_cand);
            if (hist.size() > CONF) void'(hist.pop_front());
            same = (hist.size() == CONF);
            foreach (hist[k]) if (hist[k] != st_cand) same = 0;
            if (same) e_result = st_cand;
         end
         if (m_active && VSYNC && !m_prev_v) begin
            st_red = m_red; st_blue = m_blue;
            if (m_red >= THR && m_red > m_blue) st_cand = 1;
            else if (m_blue >= THR && m_blue > m_red) st_cand = 2;
            else st_cand = 0;
            m_stage = 1; m_red = 0; m_blue = 0; m_active = 0; m_busy = 2;
         end else if (m_active && W_EN && !VSYNC && X < H && Y < V) begin
            case (classify(PIXEL_COLOR))
               1: if (m_red < 32767) m_red++;
               2: if (m_blue < 32767) m_blue++;
               default: ;
            endcase
         end else if (m_busy > 0) begin
            m_busy--;
         end else if (!m_active && m_armed && !VSYNC) begin
            m_active = 1;
         end
         if (VSYNC) m_armed = 1;
         m_prev_v = VSYNC;
      end
   end

   logic [32:0] act_v, exp_v;
   always @(negedge CLK) begin
      if (m_seen_rst) begin
         act_v = {RESULT, RESULT_VALID, RED_CNT, BLUE_CNT};
         exp_v = {e_result[1:0], e_valid[0], e_red[14:0], e_blue[14:0]};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL outputs t=%0t got res=%0d vld=%0d red=%0d blue=%0d want res=%0d vld=%0d red=%0d blue=%0d",
                     $time, RESULT, RESULT_VALID, RED_CNT, BLUE_CNT, e_result, e_valid, e_red, e_blue);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      vectors++;
      if (act !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) begin
         W_EN = 1'b1; PIXEL_COLOR = c; X = 10'(i % H); Y = 10'(i / H);
         tick();
      end
      W_EN = 1'b0;
   endtask

   task automatic send_at(input logic [7:0] c, input int n, input int x, input int y);
      for (int i = 0; i < n; i++) begin
         W_EN = 1'b1; PIXEL_COLOR = c; X = 10'(x); Y = 10'(y);
         tick();
      end
      W_EN = 1'b0;
   endtask

   // Blanking with hand-computed report expectations; we_blank keeps red
   // pixels strobing while VSYNC is high, including the rising-edge cycle.
   task automatic end_frame(input int er, input int eb, input int eres, input bit we_blank);
      W_EN = we_blank; PIXEL_COLOR = 8'hE0; X = 10'd0; Y = 10'd0; VSYNC = 1'b1;
      tick();
      chk("valid_in_decide", 32'(RESULT_VALID), 0);
      tick();
      chk("valid_in_report", 32'(RESULT_VALID), 1);
      chk("red_cnt", 32'(RED_CNT), er);
      chk("blue_cnt", 32'(BLUE_CNT), eb);
      chk("result", 32'(RESULT), eres);
      tick();
      chk("valid_after_report", 32'(RESULT_VALID), 0);
      tick();
      W_EN = 1'b0; VSYNC = 1'b0;
      tick(); tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_result", 32'(RESULT), 0);
      chk("rst_valid", 32'(RESULT_VALID), 0);
      chk("rst_red", 32'(RED_CNT), 0);
      chk("rst_blue", 32'(BLUE_CNT), 0);
      RST_N = 1'b1;
      tick();
      VSYNC = 1'b0;
      tick(); tick();

      // two full red frames: confirmation needs the second
      send(8'hE0, H * V);
      end_frame(H * V, 0, 0, 0);
      send(8'hE0, H * V);
      end_frame(H * V, 0, 1, 0);

      // blue dominant with some neither pixels
      send(8'h03, 3000);
      send(8'hE0, 1000);
      send(8'hFF, 200);
      end_frame(1000, 3000, 1, 0);

      // tie twice -> none confirmed
      send(8'hE0, 2500); send(8'h03, 2500);
      end_frame(2500, 2500, 1, 0);
      send(8'hE0, 2500); send(8'h03, 2500);
      end_frame(2500, 2500, 0, 0);

      // out-of-window pixels and pixels during blanking
      send_at(8'hE0, 50, H, 0);
      send_at(8'hE0, 50, 0, V);
      send_at(8'hE0, 50, H, V);
      end_frame(0, 0, 0, 1);

      // threshold boundary, with the last in-window corner pixel
      send(8'hE0, 1998);
      send_at(8'hE0, 1, H - 1, V - 1);
      end_frame(1999, 0, 0, 0);
      send(8'hE0, 2000);
      end_frame(2000, 0, 0, 0);
      send(8'hE0, 2000);
      end_frame(2000, 0, 1, 0);

      // reset mid-frame: partial frame produces no report
      send(8'hE0, 5000);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      chk("midrst_result", 32'(RESULT), 0);
      chk("midrst_red", 32'(RED_CNT), 0);
      send(8'hE0, 1000);
      VSYNC = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_no_pulse", 32'(RESULT_VALID), 0);
      end
      VSYNC = 1'b0;
      tick(); tick();
      send(8'hE0, 3000);
      end_frame(3000, 0, 0, 0);

      // VSYNC glitches during DECIDE/REPORT
      send(8'hE0, 2100);
      VSYNC = 1'b1;
      tick();
      chk("glitch_decide_valid", 32'(RESULT_VALID), 0);
      VSYNC = 1'b0;
      tick();
      chk("glitch_report_valid", 32'(RESULT_VALID), 1);
      chk("glitch_red", 32'(RED_CNT), 2100);
      chk("glitch_result", 32'(RESULT), 1);
      VSYNC = 1'b1;
      tick();
      chk("glitch_after_valid", 32'(RESULT_VALID), 0);
      VSYNC = 1'b0;
      tick(); tick();

      // classifier boundary colours in the frame after the glitch
      send(8'h89, 1000);
      send(8'h4F, 1200);
      send(8'h6F, 100);
      send(8'h8D, 100);
      end_frame(1000, 1200, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/color_detector.md
COLOR_DETECTOR -- requirements
Module: color_detector

Interface
REQ-001 Parameter THRESH, default 15'd2000, minimum dominant-pixel count per frame for a colour to qualify.
REQ-002 Parameter CONFIRM, default 2, consecutive identical frame decisions needed before RESULT changes; legal range 1..7.
REQ-003 Parameter H_ACTIVE, default 176, active columns; V_ACTIVE, default 144, active rows.
REQ-004 Port CLK  input  1  single system clock; every input is synchronous to it.
REQ-005 Port RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-006 Port PIXEL_COLOR  input  8  RGB332 pixel: R=[7:5], G=[4:2], B=[1:0].
REQ-007 Port W_EN  input  1  pixel-valid qualifier, high for exactly one CLK cycle per pixel.
REQ-008 Port X  input  10  column of the current pixel.
REQ-009 Port Y  input  10  row of the current pixel.
REQ-010 Port VSYNC  input  1  high during vertical blanking; the rising edge marks frame end.
REQ-011 Port RESULT  output  2  confirmed colour: 2'b00 none, 2'b01 red, 2'b10 blue; 2'b11 is never driven.
REQ-012 Port RESULT_VALID  output  1  one-cycle pulse once per frame, after the decision.
REQ-013 Port RED_CNT  output  15  red-pixel count of the last completed frame.
REQ-014 Port BLUE_CNT  output  15  blue-pixel count of the last completed frame.

Function
REQ-015 A pixel is accepted only when W_EN=1, VSYNC=0, X<H_ACTIVE and Y<V_ACTIVE are all true in the same cycle.
REQ-016 An accepted pixel is red when R>=4, G<=2 and B<=1; it is blue when B==3, R<=2 and G<=3; otherwise it is neither.
REQ-017 The red and blue accumulators are each 15 bits wide, increment by one per matching accepted pixel, and saturate at 15'h7FFF without wrapping.
REQ-018 FSM states: IDLE, ACCUM, DECIDE, REPORT.
REQ-019 Transitions: IDLE->ACCUM on the first cycle with VSYNC=0; ACCUM->DECIDE in the cycle after a registered VSYNC 0->1 edge; DECIDE->REPORT unconditionally; REPORT->IDLE unconditionally.
REQ-020 In DECIDE the candidate is red if red>=THRESH and red>blue, blue if blue>=THRESH and blue>red, and none otherwise; ties yield none.
REQ-021 A run counter increments when the candidate equals the previous frame's candidate, reloads to 1 otherwise, and saturates at CONFIRM.
REQ-022 In REPORT, RESULT takes the candidate value if the run counter equals CONFIRM; otherwise RESULT holds its previous value.
REQ-023 RESULT_VALID is high for exactly the REPORT cycle.
REQ-024 RED_CNT and BLUE_CNT load from the accumulators in DECIDE, and both accumulators clear in the same cycle.
REQ-025 Latency: with the VSYNC rising edge sampled at cycle n, DECIDE occurs at n+1 and RESULT/RESULT_VALID are visible at n+2.
REQ-026 Pixels presented outside ACCUM are ignored.
REQ-027 If VSYNC falls and rises again before REPORT completes, the FSM still completes DECIDE and REPORT, and the new frame begins from IDLE.
REQ-028 A W_EN pulse in the same cycle as the VSYNC rising edge is rejected, because VSYNC=1 in that cycle.

Reset
REQ-029 While RST_N=0 at a CLK edge: FSM=IDLE, RESULT=2'b00, RESULT_VALID=0, RED_CNT=0, BLUE_CNT=0, accumulators=0, run counter=0, previous candidate=none, VSYNC edge register=1.
REQ-030 Reset asserted mid-frame discards the partial counts, and no RESULT_VALID pulse is produced for that frame.

Structure
REQ-031 A shared package holds the RESULT encodings, the FSM state enumeration, and the RGB332 field bit positions.
REQ-032 One sub-module, pixel_classifier, holds the purely combinational red/blue decision of REQ-016, so it can be reused by later stages.

Verification
REQ-033 Full frame of 0xE0 (176x144 = 25344 pixels), CONFIRM=2, two frames -> RED_CNT=25344 both frames; RESULT stays 00 after frame 1 and becomes 01 after frame 2.
REQ-034 Frame with 3000 pixels of 0x03 and 1000 of 0xE0 -> BLUE_CNT=3000, RED_CNT=1000, candidate blue, RESULT_VALID pulse exactly 2 cycles after the VSYNC rise.
REQ-035 Equal counts of 2500 red and 2500 blue -> candidate none; RESULT unchanged after one frame and 00 after CONFIRM frames.
REQ-036 Pixels with X=176 or Y=144, or with VSYNC=1, all of value 0xE0 -> RED_CNT=0.
REQ-037 RST_N pulsed low for 1 cycle mid-frame after 5000 red pixels -> no pulse for that frame; the next full frame reports RED_CNT equal to that frame's pixels only.
REQ-038 THRESH=2000 and 1999 red pixels -> candidate none; 2000 red pixels -> candidate red.
